ula_seq: RTL

ULA_SEQ -- requirements
Module: ula_seq

---
 rtl/ula_seq_if.sv | 27 ++
 rtl/ula_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ula_seq_if.sv
// Bus bundle for ula_seq: request fields in, status and registered results out.
// start is a request with no backpressure; the unit accepts it only while IDLE and answers each accepted request with exactly one done pulse.
interface ula_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       Opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] Dados_1;
    logic [WIDTH-1:0] Dados_2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Resultado;
    logic             Zero;
    logic             DivZero;
    logic [1:0]       dbg_state;

    modport master (
        output start, Opcode, funct, Dados_1, Dados_2,
        input  busy, done, Resultado, Zero, DivZero, dbg_state
    );

    modport slave (
        input  start, Opcode, funct, Dados_1, Dados_2,
        output busy, done, Resultado, Zero, DivZero, dbg_state
    );
endinterface

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle ops plus shift-add MUL; restoring DIV is
// included only when ULA_SEQ_DIV_EN is defined.
module ula_seq #(
    parameter int WIDTH = 32
) (
    input logic        clock,
    input logic        reset,
    ula_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIM = 2'd2} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, x, y;
    logic             busy_q, done_q, zero_q, divz_q;
    logic [WIDTH-1:0] res_q;

    logic [WIDTH-1:0] a, b, res_c, acc_n, x_n, y_n;
    logic             zero_c, divz_c, multi_c;
`ifdef ULA_SEQ_DIV_EN
    logic             is_div, div_c;
    logic [WIDTH:0]   rs, trial;
`endif

    assign a = bus.Dados_1;
    assign b = bus.Dados_2;

    always_comb begin
        res_c   = '0;
        zero_c  = 1'b0;
        divz_c  = 1'b0;
        multi_c = 1'b0;
`ifdef ULA_SEQ_DIV_EN
        div_c   = 1'b0;
`endif
        case (bus.Opcode)
            6'd0: case (bus.funct)
                6'd0: res_c = a + b;
                6'd1: res_c = a - b;
                6'd2: multi_c = 1'b1;
`ifdef ULA_SEQ_DIV_EN
                6'd3: if (b == '0) begin
                    res_c  = '1;
                    divz_c = 1'b1;
                end else begin
                    multi_c = 1'b1;
                    div_c   = 1'b1;
                end
`endif
                6'd4: res_c = a + WIDTH'(1);
                6'd5: res_c = a - WIDTH'(1);
                default: res_c = '0;
            endcase
            6'd1: case (bus.funct)
                6'd0: res_c = a & b;
                6'd1: res_c = a | b;
                6'd2: res_c = ~a;
                6'd3: res_c = a ^ b;
                default: res_c = '0;
            endcase
            6'd2, 6'd6, 6'd7, 6'd8, 6'd28, 6'd30, 6'd31: res_c = a + b;
            6'd20: res_c = a - b;
            6'd3, 6'd9, 6'd33: res_c = a;
            6'd5: begin
                res_c  = b;
                zero_c = 1'b1;
            end
            6'd19: zero_c = 1'b1;
            6'd10: zero_c = (a == b);
            6'd11: zero_c = (a != b);
            6'd4:  res_c = WIDTH'(a < b);
            6'd13: res_c = WIDTH'(a != b);
            6'd15: res_c = WIDTH'(a > b);
            6'd16: res_c = WIDTH'(a == b);
            6'd17: res_c = WIDTH'(a >= b);
            6'd18: res_c = WIDTH'(a <= b);
            default: res_c = '0;
        endcase
    end

    // One iteration: MUL adds the shifted multiplicand; DIV shifts the
    // dividend (held in x) into the remainder and builds the quotient in x.
    always_comb begin
        acc_n = acc;
        x_n   = x << 1;
        y_n   = y >> 1;
        if (y[0]) acc_n = acc + x;
`ifdef ULA_SEQ_DIV_EN
        rs    = {acc, x[WIDTH-1]};
        trial = rs - {1'b0, y};
        if (is_div) begin
            y_n = y;
            if (!trial[WIDTH]) begin
                acc_n = trial[WIDTH-1:0];
                x_n   = {x[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = rs[WIDTH-1:0];
                x_n   = {x[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
            divz_q <= 1'b0;
`ifdef ULA_SEQ_DIV_EN
            is_div <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    if (multi_c) begin
                        state  <= CALC;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        acc    <= '0;
                        x      <= a;
                        y      <= b;
`ifdef ULA_SEQ_DIV_EN
                        is_div <= div_c;
`endif
                    end else begin
                        state  <= FIM;
                        done_q <= 1'b1;
                        res_q  <= res_c;
                        zero_q <= zero_c;
                        divz_q <= divz_c;
                    end
                end
                CALC: begin
                    acc <= acc_n;
                    x   <= x_n;
                    y   <= y_n;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state  <= FIM;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        zero_q <= 1'b0;
                        divz_q <= 1'b0;
`ifdef ULA_SEQ_DIV_EN
                        res_q  <= is_div ? x_n : acc_n;
`else
                        res_q  <= acc_n;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIM: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    cnt    <= '0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.Resultado = res_q;
    assign bus.Zero      = zero_q;
    assign bus.DivZero   = divz_q;
    assign bus.dbg_state = state;
endmodule
